// File: rtl/fifo_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sequencer_if
//  Brief    : Request/status/RAM-control bundle for the FIFO sequencer.
//  Revision : 1.0
// ============================================================================
interface fifo_sequencer_if #(
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic          Start;
   logic          Write;
   logic          Flush;
   logic          Done;
   logic          Err;
   logic          Busy;
   logic          wr_rd;
   logic          ChipEnable;
   logic          OutEnable;
   logic [AW-1:0] Addr;
   logic          LoadEnableW;
   logic          LoadEnableR;
   logic [AW:0]   Count;
   logic          Full;
   logic          Empty;
   logic          AlmostFull;
   logic          AlmostEmpty;

   modport master (
      output Start, Write, Flush,
      input  Done, Err, Busy, wr_rd, ChipEnable, OutEnable, Addr,
             LoadEnableW, LoadEnableR, Count, Full, Empty, AlmostFull, AlmostEmpty
   );

   modport slave (
      input  Start, Write, Flush,
      output Done, Err, Busy, wr_rd, ChipEnable, OutEnable, Addr,
             LoadEnableW, LoadEnableR, Count, Full, Empty, AlmostFull, AlmostEmpty
   );
endinterface
`default_nettype wire

// File: rtl/fifo_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sequencer
//  Brief    : Moore FSM sequencing single-port FIFO RAM writes/reads.
//  Revision : 1.0
// ============================================================================
module fifo_sequencer #(
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 1
) (
   input  wire logic         clk,
   input  wire logic         ClearAllReg,
   fifo_sequencer_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] c_depthEff = (AW+2)'(DEPTH);
   localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_afLevel  = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0]   c_aeLevel  = (AW+1)'(AE_LEVEL);

   typedef enum logic [2:0] {
      S_CLEAR   = 3'd0,
      S_IDLE    = 3'd1,
      S_SETUP_W = 3'd2,
      S_WRITE   = 3'd3,
      S_SETUP_R = 3'd4,
      S_READ    = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_err;
   logic          w_reject;
   logic [AW+1:0] w_effCount;

   // Occupancy as it will be once the transfer in flight has committed
   always_comb begin
      w_effCount = {1'b0, r_count};
      if (r_state == S_WRITE)
         w_effCount = {1'b0, r_count} + 1'b1;
      else if (r_state == S_READ)
         w_effCount = {1'b0, r_count} - 1'b1;
   end

   always_comb begin
      w_nextState = r_state;
      w_reject    = 1'b0;
      case (r_state)
         S_CLEAR:   w_nextState = S_IDLE;
         S_SETUP_W: w_nextState = S_WRITE;
         S_SETUP_R: w_nextState = S_READ;
         default: begin
            if (bus.Flush) begin
               w_nextState = S_CLEAR;
            end else if (bus.Start && bus.Write) begin
               if (w_effCount < c_depthEff) begin
                  w_nextState = S_SETUP_W;
               end else begin
                  w_nextState = S_IDLE;
                  w_reject    = 1'b1;
               end
            end else if (bus.Start && !bus.Write) begin
               if (w_effCount != '0) begin
                  w_nextState = S_SETUP_R;
               end else begin
                  w_nextState = S_IDLE;
                  w_reject    = 1'b1;
               end
            end else begin
               w_nextState = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      bus.Done        = 1'b0;
      bus.Busy        = 1'b0;
      bus.wr_rd       = 1'b0;
      bus.ChipEnable  = 1'b0;
      bus.OutEnable   = 1'b0;
      bus.LoadEnableW = 1'b0;
      bus.LoadEnableR = 1'b0;
      bus.Addr        = '0;
      case (r_state)
         S_CLEAR: bus.Busy = 1'b1;
         S_SETUP_W: begin
            bus.Busy        = 1'b1;
            bus.wr_rd       = 1'b1;
            bus.ChipEnable  = 1'b1;
            bus.LoadEnableW = 1'b1;
            bus.Addr        = r_wptr;
         end
         S_WRITE: begin
            bus.wr_rd      = 1'b1;
            bus.ChipEnable = 1'b1;
            bus.Done       = 1'b1;
            bus.Addr       = r_wptr;
         end
         S_SETUP_R: begin
            bus.Busy       = 1'b1;
            bus.ChipEnable = 1'b1;
            bus.OutEnable  = 1'b1;
            bus.Addr       = r_rptr;
         end
         S_READ: begin
            bus.ChipEnable  = 1'b1;
            bus.OutEnable   = 1'b1;
            bus.LoadEnableR = 1'b1;
            bus.Done        = 1'b1;
            bus.Addr        = r_rptr;
         end
         default: ;
      endcase
   end

   // Pointers are AW wide, so the increment wraps DEPTH-1 -> 0 by itself
   always_ff @(posedge clk or negedge ClearAllReg) begin
      if (!ClearAllReg) begin
         r_state <= S_CLEAR;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_err   <= w_reject;
         case (r_state)
            S_CLEAR: begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end
            S_WRITE: begin
               r_wptr  <= r_wptr + 1'b1;
               r_count <= r_count + 1'b1;
            end
            S_READ: begin
               r_rptr  <= r_rptr + 1'b1;
               r_count <= r_count - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.Err         = r_err;
   assign bus.Count       = r_count;
   assign bus.Full        = (r_count == c_depth);
   assign bus.Empty       = (r_count == '0);
   assign bus.AlmostFull  = (r_count >= c_afLevel);
   assign bus.AlmostEmpty = (r_count <= c_aeLevel);
endmodule
`default_nettype wire

// File: tb/tb_fifo_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sequencer
//  Brief    : Directed vector table plus multi-cycle sequences for fifo_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_fifo_sequencer;
   logic clk;
   logic rstN;
   int   checks;
   int   errors;
   int   seenAddr[$];

   fifo_sequencer_if #(.DEPTH(8)) bus ();

   fifo_sequencer #(.DEPTH(8)) dut (
      .clk         (clk),
      .ClearAllReg (rstN),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {Done,Err,Busy,wr_rd,ChipEnable,OutEnable,LoadEnableW,LoadEnableR}
   logic [7:0] actCtrl;
   logic [3:0] actFlags;
   assign actCtrl  = {bus.Done, bus.Err, bus.Busy, bus.wr_rd, bus.ChipEnable,
                      bus.OutEnable, bus.LoadEnableW, bus.LoadEnableR};
   assign actFlags = {bus.Full, bus.Empty, bus.AlmostFull, bus.AlmostEmpty};

   localparam logic [7:0] C_IDLE  = 8'b0000_0000;
   localparam logic [7:0] C_ERR   = 8'b0100_0000;
   localparam logic [7:0] C_CLEAR = 8'b0010_0000;
   localparam logic [7:0] C_SW    = 8'b0011_1010;
   localparam logic [7:0] C_WR    = 8'b1001_1000;
   localparam logic [7:0] C_SR    = 8'b0010_1100;
   localparam logic [7:0] C_RD    = 8'b1000_1101;

   typedef struct {
      logic       start;
      logic       write;
      logic       flush;
      logic [7:0] ctrl;
      logic [2:0] addr;
      logic [3:0] cnt;
      logic [3:0] flags;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic runTxn(input logic wr, input int n);
      int dones;
      dones = 0;
      seenAddr.delete();
      bus.Start = 1'b1;
      bus.Write = wr;
      for (int c = 0; c < 2 * n; c++) begin
         step();
         if (bus.Done) begin
            dones++;
            seenAddr.push_back(int'(bus.Addr));
         end
      end
      bus.Start = 1'b0;
      step();
      check("txn_dones", n, dones, n);
   endtask

   initial begin
      int doneCnt;
      int errCnt;
      int expAddr[4];
      checks = 0;
      errors = 0;
      rstN      = 1'b0;
      bus.Start = 1'b0;
      bus.Write = 1'b0;
      bus.Flush = 1'b0;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, C_IDLE,  3'd0, 4'd0, 4'b0101};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, C_ERR,   3'd0, 4'd0, 4'b0101};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, C_IDLE,  3'd0, 4'd0, 4'b0101};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, C_SW,    3'd0, 4'd0, 4'b0101};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, C_WR,    3'd0, 4'd0, 4'b0101};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, C_SW,    3'd1, 4'd1, 4'b0001};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, C_WR,    3'd1, 4'd1, 4'b0001};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, C_IDLE,  3'd0, 4'd2, 4'b0000};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, C_SR,    3'd0, 4'd2, 4'b0000};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, C_RD,    3'd0, 4'd2, 4'b0000};
      vecs[10] = '{1'b0, 1'b0, 1'b0, C_IDLE,  3'd0, 4'd1, 4'b0001};
      vecs[11] = '{1'b1, 1'b1, 1'b1, C_CLEAR, 3'd0, 4'd1, 4'b0001};
      vecs[12] = '{1'b0, 1'b0, 1'b0, C_IDLE,  3'd0, 4'd0, 4'b0101};
      vecs[13] = '{1'b1, 1'b1, 1'b0, C_SW,    3'd0, 4'd0, 4'b0101};
      vecs[14] = '{1'b0, 1'b0, 1'b1, C_WR,    3'd0, 4'd0, 4'b0101};
      vecs[15] = '{1'b0, 1'b0, 1'b1, C_CLEAR, 3'd0, 4'd1, 4'b0001};
      vecs[16] = '{1'b0, 1'b0, 1'b0, C_IDLE,  3'd0, 4'd0, 4'b0101};

      // Reset-time outputs, no clock edge needed
      #2;
      check("rst_ctrl",  0, int'(actCtrl),  int'(C_CLEAR));
      check("rst_addr",  0, int'(bus.Addr), 0);
      check("rst_count", 0, int'(bus.Count), 0);
      check("rst_flags", 0, int'(actFlags), int'(4'b0101));
      #10;
      rstN = 1'b1;
      step();

      for (int i = 0; i < 17; i++) begin
         bus.Start = vecs[i].start;
         bus.Write = vecs[i].write;
         bus.Flush = vecs[i].flush;
         step();
         check("vec_ctrl",  i, int'(actCtrl),   int'(vecs[i].ctrl));
         check("vec_addr",  i, int'(bus.Addr),  int'(vecs[i].addr));
         check("vec_count", i, int'(bus.Count), int'(vecs[i].cnt));
         check("vec_flags", i, int'(actFlags),  int'(vecs[i].flags));
      end
      bus.Start = 1'b0;
      bus.Write = 1'b0;
      bus.Flush = 1'b0;

      // Fill from empty with Start held: 8 writes, then rejections
      doneCnt   = 0;
      errCnt    = 0;
      bus.Start = 1'b1;
      bus.Write = 1'b1;
      for (int c = 0; c < 18; c++) begin
         step();
         if (bus.Done) begin
            check("fill_addr", doneCnt, int'(bus.Addr), doneCnt);
            doneCnt++;
         end
         if (bus.Err) errCnt++;
      end
      check("fill_dones", 0, doneCnt, 8);
      check("fill_errs",  0, errCnt, 2);
      check("fill_ctrl",  0, int'(actCtrl), int'(C_ERR));
      check("fill_count", 0, int'(bus.Count), 8);
      check("fill_flags", 0, int'(actFlags), int'(4'b1010));
      bus.Start = 1'b0;
      step();
      check("fill_idle", 0, int'(actCtrl), int'(C_IDLE));

      bus.Flush = 1'b1;
      step();
      check("flush_ctrl", 0, int'(actCtrl), int'(C_CLEAR));
      bus.Flush = 1'b0;
      step();
      check("flush_count", 0, int'(bus.Count), 0);
      check("flush_flags", 0, int'(actFlags), int'(4'b0101));

      // Empty read is rejected
      bus.Start = 1'b1;
      bus.Write = 1'b0;
      step();
      check("rdempty_ctrl", 0, int'(actCtrl), int'(C_ERR));
      bus.Start = 1'b0;
      step();
      check("rdempty_count", 0, int'(bus.Count), 0);
      check("rdempty_ctrl", 1, int'(actCtrl), int'(C_IDLE));

      // Write 6, read 6, write 4: write pointer wraps
      runTxn(1'b1, 6);
      check("w6_count", 0, int'(bus.Count), 6);
      runTxn(1'b0, 6);
      check("r6_count", 0, int'(bus.Count), 0);
      runTxn(1'b1, 4);
      expAddr = '{6, 7, 0, 1};
      for (int i = 0; i < 4; i++) begin
         if (i < seenAddr.size())
            check("wrap_addr", i, seenAddr[i], expAddr[i]);
         else
            check("wrap_addr", i, -1, expAddr[i]);
      end
      check("wrap_count", 0, int'(bus.Count), 4);
      check("wrap_flags", 0, int'(actFlags), int'(4'b0000));

      // Asynchronous reset during SETUP_W
      bus.Start = 1'b1;
      bus.Write = 1'b1;
      step();
      check("arst_setup", 0, int'(actCtrl), int'(C_SW));
      bus.Start = 1'b0;
      #2;
      rstN = 1'b0;
      #1;
      check("arst_ctrl",  0, int'(actCtrl), int'(C_CLEAR));
      check("arst_count", 0, int'(bus.Count), 0);
      check("arst_addr",  0, int'(bus.Addr), 0);
      for (int c = 0; c < 2; c++) begin
         step();
         check("arst_hold", c, int'(actCtrl), int'(C_CLEAR));
      end
      #2;
      rstN = 1'b1;
      step();
      check("arst_idle",  0, int'(actCtrl), int'(C_IDLE));
      check("arst_count", 1, int'(bus.Count), 0);
      check("arst_flags", 0, int'(actFlags), int'(4'b0101));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fifo_sequencer.md
FIFO_SEQUENCER -- requirements
Module: fifo_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8; number of FIFO RAM words, power of two, 4..256.
REQ-002 SHALL have parameter AF_LEVEL, default DEPTH-2; AlmostFull threshold, 1..DEPTH.
REQ-003 SHALL have parameter AE_LEVEL, default 1; AlmostEmpty threshold, 0..DEPTH-1.
REQ-004 SHALL define local AW = log2(DEPTH).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 ClearAllReg  input  1  reset, asynchronous, active-low.
REQ-007 Start  input  1  transaction request, sampled on rising clk.
REQ-008 Write  input  1  direction with Start: 1 write, 0 read.
REQ-009 Flush  input  1  synchronous empty-the-FIFO request.
REQ-010 Done  output  1  one-cycle transaction-complete strobe.
REQ-011 Err  output  1  registered one-cycle rejected-request strobe.
REQ-012 Busy  output  1  high in CLEAR, SETUP_W, SETUP_R.
REQ-013 wr_rd, ChipEnable, OutEnable  output  1 each  RAM controls, active-high.
REQ-014 Addr  output  AW  RAM address.
REQ-015 LoadEnableW, LoadEnableR  output  1 each  write/read buffer load enables.
REQ-016 Count  output  AW+1  occupancy, 0..DEPTH.
REQ-017 Full, Empty, AlmostFull, AlmostEmpty  output  1 each  status flags.

Function
REQ-018 States SHALL be CLEAR, IDLE, SETUP_W, WRITE, SETUP_R, READ; registered state, combinational next-state and Moore outputs.
REQ-019 EffCount SHALL be Count+1 in WRITE, Count-1 in READ, Count otherwise.
REQ-020 Decision states (IDLE, WRITE, READ), priority: Flush -> CLEAR; Start&Write&EffCount<DEPTH -> SETUP_W; Start&!Write&EffCount>0 -> SETUP_R; else IDLE.
REQ-021 Start&Write with EffCount==DEPTH, or Start&!Write with EffCount==0, in a decision state SHALL be rejected: Err=1 next cycle, next state IDLE, no pointer/Count change.
REQ-022 SETUP_W -> WRITE, SETUP_R -> READ, CLEAR -> IDLE unconditionally.
REQ-023 Outputs: IDLE all RAM/buffer controls 0; SETUP_W wr_rd=ChipEnable=LoadEnableW=1; WRITE wr_rd=ChipEnable=Done=1; SETUP_R ChipEnable=OutEnable=1; READ ChipEnable=OutEnable=LoadEnableR=Done=1; CLEAR all 0.
REQ-024 Addr SHALL be wptr in SETUP_W/WRITE, rptr in SETUP_R/READ, 0 otherwise.
REQ-025 On the edge leaving WRITE: wptr+1 mod DEPTH, Count+1; on the edge leaving READ: rptr+1 mod DEPTH, Count-1.
REQ-026 Pointers SHALL wrap DEPTH-1 -> 0; Count never exceeds DEPTH nor underflows.
REQ-027 In CLEAR: wptr, rptr, Count SHALL load 0 on the edge leaving CLEAR.
REQ-028 Flags combinational from Count: Full = (Count==DEPTH), Empty = (Count==0), AlmostFull = (Count>=AF_LEVEL), AlmostEmpty = (Count<=AE_LEVEL).
REQ-029 Latency: Start sampled in IDLE at edge k -> SETUP at k+1 -> transfer state with Done at k+2; Start held -> one transaction per 2 cycles.
REQ-030 Flush while in SETUP_W/SETUP_R SHALL be ignored until the next decision state; the pending transfer completes.
REQ-031 Start and Flush both high SHALL flush; Err SHALL stay 0.

Reset
REQ-032 ClearAllReg low SHALL immediately force state CLEAR, wptr=rptr=0, Count=0, Err=0, regardless of clk.
REQ-033 Outputs during reset: Done=0, all RAM/buffer controls 0, Addr=0, Busy=1, Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no Done; after release, one cycle CLEAR then IDLE.

Verification
REQ-035 DEPTH=8: reset, Start=1,Write=1 held 16 cycles -> 8 Done pulses, Addr 0..7, Full=1 at Count=8, then Err pulse, state IDLE.
REQ-036 From empty, Start=1,Write=0 one cycle -> Err=1 next cycle, Done never, Count=0.
REQ-037 Write 6, read 6, write 4 -> wptr wraps, write Addr sequence 6,7,0,1; Count=4, AlmostEmpty=0.
REQ-038 Count=7, Start=1,Write=1 held -> one Done in WRITE, next request rejected (EffCount=8), Err=1, Full=1.
REQ-039 Count=5, Flush=1 with Start=1 in IDLE -> CLEAR, then Count=0, Empty=1, Err=0.
REQ-040 ClearAllReg low during SETUP_W -> CLEAR asynchronously, no Done, Count unchanged at 0 after release.
